ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain driver for the fabric's ccff shift chains: the writing and reading end of the ccff_head → ccff_tail protocol used by every connection block, switch block and grid memory. It accepts a byte-wide bitstream from the host front end and bit-serially shifts it into a chain through a locally generated chain clock. It also performs non-destructive readback by rotating the chain contents through itself while streaming the shifted-out bits back to the host. One instance sits at the fabric top, between the host interface and the head/tail of the full configuration chain.

## Interface
- CHAIN_LEN, default 11: number of configuration flip-flops in the attached chain; must be ≥1.
- NBYTES, derived, ceil(CHAIN_LEN/8): bytes per load or readback transfer.
- prog_clk  input  1  loader clock; all state is updated on its rising edge.
- prog_reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_op  input  1  0 = LOAD, 1 = READBACK.
- wr_data  input  8  bitstream byte, consumed LSB first.
- wr_valid / wr_ready  input / output  1 / 1  write-byte handshake.
- rd_data  output  8  readback byte, LSB = earliest bit shifted out.
- rd_valid / rd_ready  output / input  1 / 1  readback-byte handshake.
- chain_clk  output  1  registered clock driven to the chain's prog_clk.
- chain_head  output  1  registered, driven to the chain's ccff_head.
- chain_tail  input  1  from the chain's ccff_tail.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, PUSH, DONE.
- IDLE
  - A LOAD command goes to FETCH.
  - A READBACK command clears the byte register and goes to SHIFT_LO.
  - Bit counter `bitcnt` (width clog2(CHAIN_LEN+1)) is cleared on command acceptance.
- FETCH (LOAD only)
  - wr_ready = 1.
  - On handshake: latch wr_data into the byte register, go to SHIFT_LO.
- SHIFT_LO (chain_clk = 0)
  - LOAD: chain_head ← byte_reg[bitcnt mod 8].
  - READBACK: chain_head ← chain_tail, and the same chain_tail value is captured into byte_reg[bitcnt mod 8].
  - Always go to SHIFT_HI.
- SHIFT_HI (chain_clk = 1)
  - The chain shifts on this rising chain_clk edge; bitcnt increments.
  - Next state:
    - bitcnt+1 == CHAIN_LEN: LOAD → DONE; READBACK → PUSH.
    - (bitcnt+1) mod 8 == 0: LOAD → FETCH; READBACK → PUSH.
    - Otherwise → SHIFT_LO.
- PUSH (READBACK only)
  - rd_valid = 1, rd_data = byte_reg.
  - On handshake: clear byte_reg; go to DONE if bitcnt == CHAIN_LEN, else SHIFT_LO.
- DONE: done = 1 for one cycle, then IDLE.
- Bit ordering: stream bit k (byte k/8, bit k%8) is the k-th bit shifted in. Padding bits of the last write byte are never shifted. Padding bits of the last read byte read 0.
- READBACK reinjects each tail bit at the head. After CHAIN_LEN shifts the chain holds its original contents and the read bytes equal the last loaded bytes (with padding bits zeroed).
- Commands presented while busy are not accepted; cmd_ready stays low.

## Timing
- Reset values: chain_clk 0, chain_head 0, cmd_ready 1 (IDLE), wr_ready 0, rd_valid 0, rd_data 0, busy 0, done 0, bitcnt 0.
- chain_clk and chain_head are flop outputs (glitch-free). chain_head changes only while chain_clk is low, giving one full prog_clk period of setup before each rising chain_clk edge.
- Per bit: exactly 2 prog_clk cycles with no stall.
- chain_clk is held low during FETCH/PUSH stalls; the chain never shifts while waiting on a handshake.
- LOAD with no stalls: CHAIN_LEN×2 + NBYTES (FETCH) + 1 (DONE) cycles from acceptance.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). The chain is left with partial contents; the host must reissue LOAD.

## Structure
- Shared package ccff_loader_pkg holds:
  - state enum `ccff_state_t`;
  - opcode constants OP_LOAD = 1'b0, OP_READBACK = 1'b1.
- Sub-module ccff_byte_shifter: 8-bit byte register with indexed bit read/write and clear, plus the mod-8 / terminal comparisons on bitcnt. The top level holds the FSM and handshakes.

## Test plan
- LOAD 0x5A, 0x03 with CHAIN_LEN = 11 against a behavioural 11-flop chain → exactly 11 chain_clk rises; chain_head sequence 0,1,0,1,1,0,1,0,1,1,0; chain holds that pattern; one done pulse.
- READBACK after that load → rd bytes 0x5A then 0x03; a second READBACK returns the same two bytes (non-destructive).
- Hold wr_valid low 20 cycles before the second byte, and rd_ready low 20 cycles during readback → chain_clk stays 0 throughout, no extra shifts, data unchanged.
- Assert cmd_valid while busy → cmd_ready stays 0 and the command is ignored; it is accepted on the cycle after done.
- Assert prog_reset after 5 shifted bits → chain_clk/busy/wr_ready drop to 0 asynchronously; a subsequent full LOAD of 0xFF, 0x07 reads back 0xFF, 0x07.
- CHAIN_LEN = 8 → LOAD of 0xA5 uses one byte and 8 shifts; READBACK returns 0xA5.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the ccff configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_PUSH     = 3'd4,
    ST_DONE     = 3'd5
  } ccff_state_t;

  localparam logic OP_LOAD     = 1'b0;
  localparam logic OP_READBACK = 1'b1;

  // Position of a stream bit inside its byte.
  function automatic logic [2:0] bit_index(input logic [31:0] n);
    return n[2:0];
  endfunction

endpackage

// File: rtl/ccff_byte_shifter.sv
// Byte staging register for the chain loader, plus the bit-counter
// comparisons (byte wrap, last bit, end of chain) the FSM steers on.
module ccff_byte_shifter
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 11,
  parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [7:0]    load_data_i,
  input  logic          wr_bit_i,
  input  logic [2:0]    wr_idx_i,
  input  logic          wr_val_i,
  input  logic [2:0]    rd_idx_i,
  output logic          rd_bit_o,
  output logic [7:0]    byte_o,
  input  logic [CW-1:0] cnt_i,
  output logic [CW-1:0] cnt_inc_o,
  output logic [2:0]    idx_o,
  output logic [2:0]    idx_inc_o,
  output logic          inc_last_o,
  output logic          inc_wrap_o,
  output logic          at_end_o
);

  logic [7:0]  byte_q;
  logic [7:0]  byte_d;
  logic [7:0]  base_s;
  logic [7:0]  bit_mask_s;
  logic [7:0]  wr_byte_s;
  logic [31:0] cnt_ext_s;
  logic [31:0] inc_ext_s;

  // Counter comparisons done at 32 bits so every CHAIN_LEN works.
  always_comb begin
    cnt_ext_s  = 32'(cnt_i);
    inc_ext_s  = cnt_ext_s + 32'd1;
    cnt_inc_o  = inc_ext_s[CW-1:0];
    idx_o      = bit_index(cnt_ext_s);
    idx_inc_o  = bit_index(inc_ext_s);
    inc_last_o = (inc_ext_s == 32'(CHAIN_LEN));
    inc_wrap_o = (bit_index(inc_ext_s) == 3'd0);
    at_end_o   = (cnt_ext_s == 32'(CHAIN_LEN));
  end

  // A clear may be combined with a bit write: the write lands in the cleared byte.
  always_comb begin
    base_s     = clr_i ? 8'h00 : byte_q;
    bit_mask_s = 8'h01 << wr_idx_i;
    wr_byte_s  = wr_bit_i ? ((base_s & ~bit_mask_s) | (wr_val_i ? bit_mask_s : 8'h00))
                          : base_s;
    byte_d     = load_i ? load_data_i : wr_byte_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign rd_bit_o = byte_q[rd_idx_i];
  assign byte_o   = byte_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Bit-serial writer/reader for a ccff_head -> ccff_tail configuration chain,
// with a locally generated chain clock and rotate-through readback.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 11
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       chain_clk,
  output logic       chain_head,
  input  logic       chain_tail,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  ccff_state_t   state_q;
  ccff_state_t   state_d;
  logic          op_q;
  logic          op_d;
  logic [CW-1:0] bitcnt_q;
  logic [CW-1:0] bitcnt_d;
  logic          chain_head_q;
  logic          chain_head_d;
  logic          chain_clk_q;
  logic          cmd_ready_q;
  logic          wr_ready_q;
  logic          rd_valid_q;
  logic          busy_q;
  logic          done_q;

  logic          sh_clr_s;
  logic          sh_load_s;
  logic          sh_wr_bit_s;
  logic [2:0]    sh_wr_idx_s;
  logic          sh_wr_val_s;
  logic          rd_bit_s;
  logic [7:0]    byte_s;
  logic [CW-1:0] cnt_inc_s;
  logic [2:0]    idx_s;
  logic [2:0]    idx_inc_s;
  logic          inc_last_s;
  logic          inc_wrap_s;
  logic          at_end_s;

  ccff_byte_shifter #(
    .CHAIN_LEN (CHAIN_LEN),
    .CW        (CW)
  ) u_shifter (
    .clk_i       (prog_clk),
    .rst_i       (prog_reset),
    .clr_i       (sh_clr_s),
    .load_i      (sh_load_s),
    .load_data_i (wr_data),
    .wr_bit_i    (sh_wr_bit_s),
    .wr_idx_i    (sh_wr_idx_s),
    .wr_val_i    (sh_wr_val_s),
    .rd_idx_i    (idx_inc_s),
    .rd_bit_o    (rd_bit_s),
    .byte_o      (byte_s),
    .cnt_i       (bitcnt_q),
    .cnt_inc_o   (cnt_inc_s),
    .idx_o       (idx_s),
    .idx_inc_o   (idx_inc_s),
    .inc_last_o  (inc_last_s),
    .inc_wrap_o  (inc_wrap_s),
    .at_end_o    (at_end_s)
  );

  // The head bit for the next shift is registered on entry to SHIFT_LO, so it
  // is stable for a full low phase before chain_clk rises in SHIFT_HI.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    bitcnt_d     = bitcnt_q;
    chain_head_d = chain_head_q;
    sh_clr_s     = 1'b0;
    sh_load_s    = 1'b0;
    sh_wr_bit_s  = 1'b0;
    sh_wr_idx_s  = 3'd0;
    sh_wr_val_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          bitcnt_d = {CW{1'b0}};
          if (cmd_op == OP_LOAD) begin
            state_d = ST_FETCH;
          end else begin
            state_d      = ST_SHIFT_LO;
            sh_clr_s     = 1'b1;
            sh_wr_bit_s  = 1'b1;
            sh_wr_idx_s  = 3'd0;
            sh_wr_val_s  = chain_tail;
            chain_head_d = chain_tail;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (wr_valid) begin
          sh_load_s    = 1'b1;
          state_d      = ST_SHIFT_LO;
          chain_head_d = wr_data[idx_s];
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_SHIFT_LO: begin
        state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        bitcnt_d = cnt_inc_s;
        if (inc_last_s) begin
          state_d = (op_q == OP_LOAD) ? ST_DONE : ST_PUSH;
        end else if (inc_wrap_s) begin
          state_d = (op_q == OP_LOAD) ? ST_FETCH : ST_PUSH;
        end else begin
          state_d = ST_SHIFT_LO;
          if (op_q == OP_LOAD) begin
            chain_head_d = rd_bit_s;
          end else begin
            chain_head_d = chain_tail;
            sh_wr_bit_s  = 1'b1;
            sh_wr_idx_s  = idx_inc_s;
            sh_wr_val_s  = chain_tail;
          end
        end
      end
      ST_PUSH: begin
        if (rd_ready) begin
          sh_clr_s = 1'b1;
          if (at_end_s) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_SHIFT_LO;
            sh_wr_bit_s  = 1'b1;
            sh_wr_idx_s  = idx_s;
            sh_wr_val_s  = chain_tail;
            chain_head_d = chain_tail;
          end
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LOAD;
      bitcnt_q     <= {CW{1'b0}};
      chain_head_q <= 1'b0;
      chain_clk_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      wr_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      bitcnt_q     <= bitcnt_d;
      chain_head_q <= chain_head_d;
      chain_clk_q  <= (state_d == ST_SHIFT_HI);
      cmd_ready_q  <= (state_d == ST_IDLE);
      wr_ready_q   <= (state_d == ST_FETCH);
      rd_valid_q   <= (state_d == ST_PUSH);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wr_ready   = wr_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = byte_s;
  assign chain_clk  = chain_clk_q;
  assign chain_head = chain_head_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: an 11-flop and an 8-flop behavioural chain,
// each driven by its own loader instance.
module tb_ccff_chain_loader;

  logic       prog_clk = 1'b0;
  logic       prog_reset;
  logic       cmd_valid_s [2];
  logic       cmd_op_s    [2];
  logic       wr_valid_s  [2];
  logic       rd_ready_s  [2];
  logic [7:0] wr_data_s   [2];
  logic       cmd_ready_w [2];
  logic       wr_ready_w  [2];
  logic       rd_valid_w  [2];
  logic       chain_clk_w [2];
  logic       chain_head_w[2];
  logic       chain_tail_w[2];
  logic       busy_w      [2];
  logic       done_w      [2];
  logic [7:0] rd_data_w   [2];

  int   checks = 0;
  int   errors = 0;
  logic tmo;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(11)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset),
    .cmd_valid(cmd_valid_s[0]), .cmd_ready(cmd_ready_w[0]), .cmd_op(cmd_op_s[0]),
    .wr_data(wr_data_s[0]), .wr_valid(wr_valid_s[0]), .wr_ready(wr_ready_w[0]),
    .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .rd_ready(rd_ready_s[0]),
    .chain_clk(chain_clk_w[0]), .chain_head(chain_head_w[0]), .chain_tail(chain_tail_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(8)) dut8 (
    .prog_clk(prog_clk), .prog_reset(prog_reset),
    .cmd_valid(cmd_valid_s[1]), .cmd_ready(cmd_ready_w[1]), .cmd_op(cmd_op_s[1]),
    .wr_data(wr_data_s[1]), .wr_valid(wr_valid_s[1]), .wr_ready(wr_ready_w[1]),
    .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .rd_ready(rd_ready_s[1]),
    .chain_clk(chain_clk_w[1]), .chain_head(chain_head_w[1]), .chain_tail(chain_tail_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  // Behavioural chains: bit 0 is the newest bit, bit LEN-1 drives ccff_tail.
  logic [15:0] chain0 = 16'h0;
  logic [15:0] chain1 = 16'h0;
  int rises0 = 0, rises1 = 0;
  int done0 = 0, done1 = 0, busy0 = 0, viol0 = 0;

  always @(posedge chain_clk_w[0]) begin
    chain0 <= {chain0[14:0], chain_head_w[0]};
    rises0 <= rises0 + 1;
  end

  always @(posedge chain_clk_w[1]) begin
    chain1 <= {chain1[14:0], chain_head_w[1]};
    rises1 <= rises1 + 1;
  end

  assign chain_tail_w[0] = chain0[10];
  assign chain_tail_w[1] = chain1[7];

  always @(posedge prog_clk) begin
    if (done_w[0]) done0 <= done0 + 1;
    if (done_w[1]) done1 <= done1 + 1;
    if (busy_w[0]) busy0 <= busy0 + 1;
    if (busy_w[0] && cmd_ready_w[0]) viol0 <= viol0 + 1;
  end

  function automatic int len_of(input int d);
    return (d == 0) ? 11 : 8;
  endfunction

  function automatic int rises(input int d);
    return (d == 0) ? rises0 : rises1;
  endfunction

  function automatic int dones(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  function automatic logic [15:0] chain_of(input int d);
    logic [15:0] m;
    m = (16'h1 << len_of(d)) - 16'h1;
    return ((d == 0) ? chain0 : chain1) & m;
  endfunction

  // Stream bit k is bit k%8 of byte k/8; the k-th shifted bit ends up LEN-1-k from the head.
  function automatic logic [15:0] exp_chain(input int len, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] st;
    logic [15:0] r;
    st = {b1, b0};
    r  = 16'h0;
    for (int k = 0; k < len; k++) r[len-1-k] = st[k];
    return r;
  endfunction

  function automatic logic [7:0] exp_rd(input int len, input int i, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] st;
    logic [7:0]  r;
    st = {b1, b0};
    r  = 8'h00;
    for (int j = 0; j < 8; j++) if (8 * i + j < len) r[j] = st[8*i+j];
    return r;
  endfunction

  task automatic send_cmd(input int d, input logic op);
    int n;
    n = 0;
    @(negedge prog_clk);
    cmd_valid_s[d] = 1'b1;
    cmd_op_s[d]    = op;
    while (cmd_ready_w[d] !== 1'b1 && n < 400) begin @(negedge prog_clk); n++; end
    if (n >= 400) tmo = 1'b1;
    @(negedge prog_clk);
    cmd_valid_s[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int stall,
                           output int pre, output int post);
    int n;
    n = 0;
    if (stall > 0) begin
      while (wr_ready_w[d] !== 1'b1 && n < 400) begin @(negedge prog_clk); n++; end
    end
    pre = rises(d);
    repeat (stall) @(negedge prog_clk);
    post = rises(d);
    wr_valid_s[d] = 1'b1;
    wr_data_s[d]  = b;
    while (wr_ready_w[d] !== 1'b1 && n < 400) begin @(negedge prog_clk); n++; end
    if (n >= 400) tmo = 1'b1;
    @(negedge prog_clk);
    wr_valid_s[d] = 1'b0;
  endtask

  task automatic recv_byte(input int d, output logic [7:0] b, input int stall,
                           output int pre, output int post);
    int n;
    n = 0;
    while (rd_valid_w[d] !== 1'b1 && n < 400) begin @(negedge prog_clk); n++; end
    if (n >= 400) tmo = 1'b1;
    pre = rises(d);
    repeat (stall) @(negedge prog_clk);
    post = rises(d);
    b = rd_data_w[d];
    rd_ready_s[d] = 1'b1;
    @(negedge prog_clk);
    rd_ready_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (done_w[d] !== 1'b1 && n < 400) begin @(negedge prog_clk); n++; end
    if (n >= 400) tmo = 1'b1;
  endtask

  task automatic do_load(input int d, input logic [7:0] b0, input logic [7:0] b1,
                         input int stall1, output int pre, output int post);
    int p0, q0;
    send_cmd(d, 1'b0);
    send_byte(d, b0, 0, p0, q0);
    pre = p0;
    post = q0;
    if (len_of(d) > 8) send_byte(d, b1, stall1, pre, post);
    wait_done(d);
    @(negedge prog_clk);
  endtask

  task automatic do_readback(input int d, output logic [7:0] r0, output logic [7:0] r1,
                             input int stall0, output int pre, output int post);
    int p1, q1;
    r1 = 8'h00;
    send_cmd(d, 1'b1);
    recv_byte(d, r0, stall0, pre, post);
    if (len_of(d) > 8) recv_byte(d, r1, 0, p1, q1);
    wait_done(d);
    @(negedge prog_clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (cmd_ready_w[d] !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready d%0d got %b exp 1", d, cmd_ready_w[d]); end
      checks++; if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d%0d got %b exp 0", d, busy_w[d]); end
      checks++; if (chain_clk_w[d] !== 1'b0) begin errors++; $display("FAIL reset_chain_clk d%0d got %b exp 0", d, chain_clk_w[d]); end
      checks++; if (chain_head_w[d] !== 1'b0) begin errors++; $display("FAIL reset_chain_head d%0d got %b exp 0", d, chain_head_w[d]); end
      checks++; if ({wr_ready_w[d], rd_valid_w[d], done_w[d]} !== 3'b000) begin errors++; $display("FAIL reset_handshakes d%0d got %b%b%b exp 000", d, wr_ready_w[d], rd_valid_w[d], done_w[d]); end
      checks++; if (rd_data_w[d] !== 8'h00) begin errors++; $display("FAIL reset_rd_data d%0d got %h exp 00", d, rd_data_w[d]); end
    end
  endtask

  task automatic test_load_directed();
    int r_pre, d_pre, b_pre, p, q;
    tmo = 1'b0;
    r_pre = rises0; d_pre = done0; b_pre = busy0;
    do_load(0, 8'h5A, 8'h03, 0, p, q);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL load_timeout got %b exp 0", tmo); end
    checks++; if (rises0 - r_pre !== 11) begin errors++; $display("FAIL load_chain_clk_rises got %0d exp 11", rises0 - r_pre); end
    checks++; if (chain_of(0) !== 16'b01011010110) begin errors++; $display("FAIL load_head_sequence got %b exp 01011010110", chain_of(0)); end
    checks++; if (done0 - d_pre !== 1) begin errors++; $display("FAIL load_done_pulses got %0d exp 1", done0 - d_pre); end
    checks++; if (busy0 - b_pre !== 11 * 2 + 2 + 1) begin errors++; $display("FAIL load_latency got %0d exp %0d", busy0 - b_pre, 11 * 2 + 2 + 1); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL load_done_width got %b exp 0", done_w[0]); end
  endtask

  task automatic test_readback_twice();
    logic [7:0] r0, r1;
    int r_pre, d_pre, p, q;
    for (int rep = 0; rep < 2; rep++) begin
      tmo = 1'b0;
      r_pre = rises0; d_pre = done0;
      do_readback(0, r0, r1, 0, p, q);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rb_timeout rep%0d got %b exp 0", rep, tmo); end
      checks++; if (r0 !== 8'h5A) begin errors++; $display("FAIL rb_byte0 rep%0d got %h exp 5a", rep, r0); end
      checks++; if (r1 !== 8'h03) begin errors++; $display("FAIL rb_byte1 rep%0d got %h exp 03", rep, r1); end
      checks++; if (rises0 - r_pre !== 11) begin errors++; $display("FAIL rb_rises rep%0d got %0d exp 11", rep, rises0 - r_pre); end
      checks++; if (chain_of(0) !== exp_chain(11, 8'h5A, 8'h03)) begin errors++; $display("FAIL rb_chain_intact rep%0d got %b", rep, chain_of(0)); end
      checks++; if (done0 - d_pre !== 1) begin errors++; $display("FAIL rb_done rep%0d got %0d exp 1", rep, done0 - d_pre); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] b0, b1, r0, r1;
    int pre, post, r_pre;
    tmo = 1'b0;
    b0 = 8'($urandom); b1 = 8'($urandom);
    r_pre = rises0;
    do_load(0, b0, b1, 20, pre, post);
    checks++; if (post !== pre) begin errors++; $display("FAIL stall_wr_shifts got %0d exp 0", post - pre); end
    checks++; if (rises0 - r_pre !== 11) begin errors++; $display("FAIL stall_load_rises got %0d exp 11", rises0 - r_pre); end
    checks++; if (chain_of(0) !== exp_chain(11, b0, b1)) begin errors++; $display("FAIL stall_load_chain got %b exp %b", chain_of(0), exp_chain(11, b0, b1)); end
    do_readback(0, r0, r1, 20, pre, post);
    checks++; if (post !== pre) begin errors++; $display("FAIL stall_rd_shifts got %0d exp 0", post - pre); end
    checks++; if ({r1, r0} !== {exp_rd(11, 1, b0, b1), exp_rd(11, 0, b0, b1)}) begin errors++; $display("FAIL stall_rd_data got %h%h exp %h%h", r1, r0, exp_rd(11, 1, b0, b1), exp_rd(11, 0, b0, b1)); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b exp 0", tmo); end
  endtask

  task automatic test_busy_cmd();
    logic [7:0] b0, b1, r0, r1;
    int r_pre, v_pre, p, q;
    tmo = 1'b0;
    b0 = 8'($urandom); b1 = 8'($urandom);
    r_pre = rises0; v_pre = viol0;
    send_cmd(0, 1'b0);
    cmd_valid_s[0] = 1'b1;
    cmd_op_s[0]    = 1'b1;
    send_byte(0, b0, 0, p, q);
    send_byte(0, b1, 0, p, q);
    wait_done(0);
    checks++; if (viol0 - v_pre !== 0) begin errors++; $display("FAIL busy_cmd_ready got %0d busy cycles with cmd_ready exp 0", viol0 - v_pre); end
    checks++; if (rises0 - r_pre !== 11) begin errors++; $display("FAIL busy_cmd_ignored rises got %0d exp 11", rises0 - r_pre); end
    @(negedge prog_clk);
    checks++; if (cmd_ready_w[0] !== 1'b1) begin errors++; $display("FAIL busy_ready_after_done got %b exp 1", cmd_ready_w[0]); end
    @(negedge prog_clk);
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL busy_cmd_accepted got %b exp 1", busy_w[0]); end
    cmd_valid_s[0] = 1'b0;
    recv_byte(0, r0, 0, p, q);
    recv_byte(0, r1, 0, p, q);
    wait_done(0);
    @(negedge prog_clk);
    checks++; if ({r1, r0} !== {exp_rd(11, 1, b0, b1), exp_rd(11, 0, b0, b1)}) begin errors++; $display("FAIL busy_rd_data got %h%h exp %h%h", r1, r0, exp_rd(11, 1, b0, b1), exp_rd(11, 0, b0, b1)); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL busy_timeout got %b exp 0", tmo); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r0, r1;
    int r_pre, n, p, q;
    tmo = 1'b0;
    r_pre = rises0;
    send_cmd(0, 1'b0);
    send_byte(0, 8'($urandom), 0, p, q);
    n = 0;
    while (rises0 - r_pre < 5 && n < 100) begin @(posedge prog_clk); #2; n++; end
    checks++; if (chain_clk_w[0] !== 1'b1 || rises0 - r_pre !== 5) begin errors++; $display("FAIL rst_mid_setup clk %b rises %0d exp 1 5", chain_clk_w[0], rises0 - r_pre); end
    prog_reset = 1'b1;
    #1;
    checks++; if ({chain_clk_w[0], busy_w[0], wr_ready_w[0]} !== 3'b000) begin errors++; $display("FAIL rst_mid_async got %b%b%b exp 000", chain_clk_w[0], busy_w[0], wr_ready_w[0]); end
    checks++; if ({cmd_ready_w[0], chain_head_w[0], done_w[0]} !== 3'b100) begin errors++; $display("FAIL rst_mid_idle got %b%b%b exp 100", cmd_ready_w[0], chain_head_w[0], done_w[0]); end
    @(negedge prog_clk);
    prog_reset = 1'b0;
    do_load(0, 8'hFF, 8'h07, 0, p, q);
    do_readback(0, r0, r1, 0, p, q);
    checks++; if ({r1, r0} !== 16'h07FF) begin errors++; $display("FAIL rst_mid_reload got %h%h exp 07ff", r1, r0); end
    checks++; if (chain_of(0) !== 16'h07FF) begin errors++; $display("FAIL rst_mid_chain got %h exp 07ff", chain_of(0)); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout got %b exp 0", tmo); end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, r0, r1;
    int p, q, r_pre;
    for (int it = 0; it < 6; it++) begin
      tmo = 1'b0;
      b0 = 8'($urandom); b1 = 8'($urandom);
      r_pre = rises0;
      do_load(0, b0, b1, int'($urandom_range(0, 3)), p, q);
      checks++; if (chain_of(0) !== exp_chain(11, b0, b1)) begin errors++; $display("FAIL rand_chain it%0d got %b exp %b", it, chain_of(0), exp_chain(11, b0, b1)); end
      do_readback(0, r0, r1, int'($urandom_range(0, 3)), p, q);
      checks++; if ({r1, r0} !== {exp_rd(11, 1, b0, b1), exp_rd(11, 0, b0, b1)}) begin errors++; $display("FAIL rand_rd it%0d got %h%h exp %h%h", it, r1, r0, exp_rd(11, 1, b0, b1), exp_rd(11, 0, b0, b1)); end
      checks++; if (rises0 - r_pre !== 22 || tmo !== 1'b0) begin errors++; $display("FAIL rand_rises it%0d got %0d tmo %b exp 22 0", it, rises0 - r_pre, tmo); end
    end
  endtask

  task automatic test_len8();
    logic [7:0] b, r0, r1;
    int p, q, r_pre, d_pre;
    for (int it = 0; it < 2; it++) begin
      tmo = 1'b0;
      b = (it == 0) ? 8'hA5 : 8'($urandom);
      r_pre = rises(1); d_pre = dones(1);
      do_load(1, b, 8'h00, 0, p, q);
      checks++; if (rises(1) - r_pre !== 8) begin errors++; $display("FAIL len8_rises it%0d got %0d exp 8", it, rises(1) - r_pre); end
      checks++; if (chain_of(1) !== exp_chain(8, b, 8'h00)) begin errors++; $display("FAIL len8_chain it%0d got %b exp %b", it, chain_of(1), exp_chain(8, b, 8'h00)); end
      do_readback(1, r0, r1, 0, p, q);
      checks++; if (r0 !== b) begin errors++; $display("FAIL len8_rd it%0d got %h exp %h", it, r0, b); end
      checks++; if (dones(1) - d_pre !== 2 || tmo !== 1'b0) begin errors++; $display("FAIL len8_done it%0d got %0d tmo %b exp 2 0", it, dones(1) - d_pre, tmo); end
    end
  endtask

  initial begin
    prog_reset = 1'b1;
    tmo = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cmd_valid_s[d] = 1'b0; cmd_op_s[d] = 1'b0; wr_valid_s[d] = 1'b0;
      rd_ready_s[d]  = 1'b0; wr_data_s[d] = 8'h00;
    end
    repeat (3) @(negedge prog_clk);
    test_reset();
    prog_reset = 1'b0;
    repeat (2) @(negedge prog_clk);
    test_reset();
    test_load_directed();
    test_readback_twice();
    test_stall();
    test_busy_cmd();
    test_reset_mid();
    test_random();
    test_len8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
